// File: rtl/dtc_event_builder.sv
// Event builder: walks the unmasked DTC event RAMs in port order and emits one
// framed 32-bit stream (event header, channel headers + payload, trailer).
module dtc_event_builder #(
  parameter int          NCH        = 20,
  parameter int          RAM_LAT    = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  EVT_MARK   = 8'hEB,
  parameter logic [7:0]  CH_MARK    = 8'hC0,
  parameter logic [7:0]  TRL_MARK   = 8'hEE
) (
  input  logic              DtcRamclkb,
  input  logic              reset_n,
  input  logic              DtcRamFlag,
  input  logic [NCH-1:0]    dtc_mask,
  output logic [NCH-1:0]    DtcRamenb,
  output logic [9:0]        DtcRamaddrb,
  input  logic [33*NCH-1:0] DtcRamdoutb,
  output logic              DtcRamReadConfirm,
  output logic [31:0]       rdo_data,
  output logic              rdo_sof,
  output logic              rdo_eof,
  output logic              rdo_valid,
  input  logic              rdo_ready,
  output logic              busy,
  output logic [19:0]       evt_cnt,
  output logic [2:0]        dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(RAM_LAT + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_EVHDR, S_SCAN, S_HDR_RD, S_PAYLOAD, S_TRAILER, S_CONFIRM, S_WAITCLR
  } state_t;

  state_t           r_state, w_next;
  logic             r_flag_m, r_flag_s;
  logic [NCH-1:0]   r_mask;
  logic [4:0]       r_port;
  logic             r_started, r_hdr_issued, r_trl_pushed;
  logic [9:0]       r_n;
  logic [10:0]      r_rd_addr;
  logic [9:0]       r_addr_hold;
  logic [RAM_LAT-1:0] r_pipe;
  logic [31:0]      r_mux_data;
  logic             r_mux_vld;
  logic [19:0]      r_wcnt;
  logic [19:0]      r_evt_cnt;

  logic [33:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;

  logic [4:0]       w_next_port;
  logic             w_port_found;
  logic [IW-1:0]    w_inflight;
  logic             w_credit, w_full, w_pop;
  logic             w_rd_issue;
  logic [9:0]       w_rd_addr;
  logic             w_fifo_wr;
  logic [33:0]      w_fifo_din;
  logic [31:0]      w_ram_word;

  // Valid/ready: a word transfers on a rising edge where rdo_valid & rdo_ready;
  // while rdo_valid is high and rdo_ready low the head word is held unchanged.
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = (r_cnt != '0) && rdo_ready;

  always_comb begin
    w_port_found = 1'b0;
    w_next_port  = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (!r_mask[j] && (!r_started || j > int'(r_port))) begin
        w_port_found = 1'b1;
        w_next_port  = 5'(j);
      end
    end
  end

  // Reads still travelling through the RAM and the registered output mux.
  always_comb begin
    w_inflight = IW'(r_mux_vld);
    for (int i = 0; i < RAM_LAT; i++) w_inflight = w_inflight + IW'(r_pipe[i]);
  end

  assign w_credit   = (int'(r_cnt) + int'(w_inflight)) < FIFO_DEPTH;
  assign w_ram_word = DtcRamdoutb[33*int'(r_port) +: 32];

  always_comb begin
    w_next     = r_state;
    w_rd_issue = 1'b0;
    w_rd_addr  = r_addr_hold;
    w_fifo_wr  = 1'b0;
    w_fifo_din = '0;
    case (r_state)
      S_IDLE: if (r_flag_s && !(&dtc_mask)) w_next = S_EVHDR;
      S_EVHDR: begin
        if (!w_full) begin
          w_fifo_wr  = 1'b1;
          w_fifo_din = {2'b01, EVT_MARK, 4'h0, r_evt_cnt};
          w_next     = S_SCAN;
        end
      end
      S_SCAN: w_next = w_port_found ? S_HDR_RD : S_TRAILER;
      S_HDR_RD: begin
        if (!r_hdr_issued && w_credit) begin
          w_rd_issue = 1'b1;
          w_rd_addr  = '0;
        end
        if (r_mux_vld) begin
          w_fifo_wr  = 1'b1;
          w_fifo_din = {2'b00, CH_MARK, 3'b000, r_port, 6'b000000, r_mux_data[9:0]};
          w_next     = (r_mux_data[9:0] == '0) ? S_SCAN : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (r_rd_addr <= {1'b0, r_n} && w_credit) begin
          w_rd_issue = 1'b1;
          w_rd_addr  = r_rd_addr[9:0];
        end
        if (r_mux_vld) begin
          w_fifo_wr  = 1'b1;
          w_fifo_din = {2'b00, r_mux_data};
        end
        if (r_rd_addr > {1'b0, r_n} && w_inflight == '0) w_next = S_SCAN;
      end
      S_TRAILER: begin
        if (!r_trl_pushed && !w_full) begin
          w_fifo_wr  = 1'b1;
          w_fifo_din = {2'b10, TRL_MARK, 4'h0, r_wcnt};
        end
        if (r_trl_pushed && r_cnt == '0) w_next = S_CONFIRM;
      end
      S_CONFIRM: w_next = S_WAITCLR;
      S_WAITCLR: if (!r_flag_s) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge DtcRamclkb or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_flag_m     <= 1'b0;
      r_flag_s     <= 1'b0;
      r_mask       <= '1;
      r_port       <= '0;
      r_started    <= 1'b0;
      r_hdr_issued <= 1'b0;
      r_trl_pushed <= 1'b0;
      r_n          <= '0;
      r_rd_addr    <= '0;
      r_addr_hold  <= '0;
      r_pipe       <= '0;
      r_mux_data   <= '0;
      r_mux_vld    <= 1'b0;
      r_wcnt       <= '0;
      r_evt_cnt    <= '0;
    end else begin
      r_flag_m <= DtcRamFlag;
      r_flag_s <= r_flag_m;
      r_state  <= w_next;
      if (r_state == S_IDLE && w_next == S_EVHDR) begin
        r_mask       <= dtc_mask;
        r_started    <= 1'b0;
        r_port       <= '0;
        r_wcnt       <= '0;
        r_trl_pushed <= 1'b0;
      end
      if (w_fifo_wr && !w_fifo_din[33]) r_wcnt <= r_wcnt + 20'd1;
      if (r_state == S_TRAILER && w_fifo_wr) r_trl_pushed <= 1'b1;
      if (r_state == S_SCAN && w_port_found) begin
        r_port       <= w_next_port;
        r_started    <= 1'b1;
        r_hdr_issued <= 1'b0;
      end
      if (w_rd_issue) begin
        r_addr_hold <= w_rd_addr;
        if (r_state == S_HDR_RD) r_hdr_issued <= 1'b1;
        else                     r_rd_addr    <= r_rd_addr + 11'd1;
      end
      if (r_state == S_HDR_RD && r_mux_vld) begin
        r_n       <= r_mux_data[9:0];
        r_rd_addr <= 11'd1;
      end
      if (r_state == S_CONFIRM) r_evt_cnt <= r_evt_cnt + 20'd1;
      r_pipe[0] <= w_rd_issue;
      for (int i = 1; i < RAM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_mux_vld <= r_pipe[RAM_LAT-1];
      if (r_pipe[RAM_LAT-1]) r_mux_data <= w_ram_word;
    end
  end

  // Output skid FIFO; the credit check guarantees a write never hits a full FIFO.
  always_ff @(posedge DtcRamclkb or negedge reset_n) begin
    if (!reset_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_fifo_wr) r_wp <= r_wp + PW'(1);
      if (w_pop)     r_rp <= r_rp + PW'(1);
      case ({w_fifo_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge DtcRamclkb) begin
    if (w_fifo_wr) r_mem[r_wp] <= w_fifo_din;
  end

  assign rdo_valid         = (r_cnt != '0);
  assign rdo_data          = rdo_valid ? r_mem[r_rp][31:0] : '0;
  assign rdo_sof           = rdo_valid & r_mem[r_rp][32];
  assign rdo_eof           = rdo_valid & r_mem[r_rp][33];
  assign DtcRamenb         = w_rd_issue ? ({{(NCH-1){1'b0}}, 1'b1} << r_port) : '0;
  assign DtcRamaddrb       = w_rd_addr;
  assign DtcRamReadConfirm = (r_state == S_CONFIRM);
  assign busy              = (r_state != S_IDLE);
  assign evt_cnt           = r_evt_cnt;
  assign dbg_state         = r_state;

endmodule
